// File: rtl/spi_target.sv
// SPI responder: command/address/data deserialiser backed by a local word memory, with serial read-back.
// Build option SPI_TARGET_AUTOINC_EN: data words keep streaming at addr+4 while CS stays low.
module spi_target #(
  parameter int MEM_DEPTH    = 64,
  parameter int DUMMY_CYCLES = 34
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        spi_sclk_i,
  input  logic        spi_sdi_i,
  input  logic        spi_cs_i,
  output logic        spi_sdo_o,
  output logic        spi_oe_o,
  output logic        wr_valid_o,
  output logic [31:0] wr_addr_o,
  output logic [31:0] wr_data_o,
  output logic        cmd_err_o,
  output logic [7:0]  txn_count_o
);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam int CW = 16;
  localparam logic [CW-1:0] CNT_BYTE  = CW'(7);
  localparam logic [CW-1:0] CNT_WORD  = CW'(31);
  localparam logic [CW-1:0] CNT_DUMMY = CW'(DUMMY_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_WDATA, S_RDATA, S_IGNORE
  } state_t;

  state_t        r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic          r_sclk_q;
  logic          w_rise;
  logic [31:0]   r_sh_in, w_sh_in_next;
  logic [31:0]   r_sh_out;
  logic [31:0]   r_addr;
  logic          r_mode_rd;
  logic [31:0]   r_mem [MEM_DEPTH];
  logic [IW-1:0] w_rd_idx;
  logic [31:0]   w_rd_word;
  logic          w_commit, w_load, w_shift, w_rd_done;
  logic          w_cmd_err, w_cmd_done, w_addr_done;
  logic          r_sdo, r_oe, r_wr_valid, r_cmd_err;
  logic [31:0]   r_wr_addr, r_wr_data;
  logic [7:0]    r_txn;

`ifdef SPI_TARGET_AUTOINC_EN
  logic [31:0] w_addr_inc;
  assign w_addr_inc = r_addr + 32'd4;
`endif

  assign w_rise       = spi_sclk_i & ~r_sclk_q;
  assign w_sh_in_next = {r_sh_in[30:0], spi_sdi_i};
  assign w_rd_word    = r_mem[w_rd_idx];

  // The counter holds "edges remaining minus one" for the current phase.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_commit     = 1'b0;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_rd_done    = 1'b0;
    w_cmd_err    = 1'b0;
    w_cmd_done   = 1'b0;
    w_addr_done  = 1'b0;
    w_rd_idx     = r_addr[IW+1:2];
    if (spi_cs_i) begin
      w_state_next = S_IDLE;
      w_cnt_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = S_CMD;
          w_cnt_next   = CNT_BYTE;
        end
        S_CMD: if (w_rise) begin
          if (r_cnt == '0) begin
            w_cmd_done = 1'b1;
            w_cnt_next = CNT_WORD;
            if (w_sh_in_next[7:0] == 8'h02 || w_sh_in_next[7:0] == 8'h0B) begin
              w_state_next = S_ADDR;
            end else begin
              w_state_next = S_IGNORE;
              w_cmd_err    = 1'b1;
            end
          end else begin
            w_cnt_next = r_cnt - CW'(1);
          end
        end
        S_ADDR: if (w_rise) begin
          if (r_cnt == '0) begin
            w_addr_done = 1'b1;
            if (!r_mode_rd) begin
              w_state_next = S_WDATA;
              w_cnt_next   = CNT_WORD;
            end else if (DUMMY_CYCLES > 0) begin
              w_state_next = S_DUMMY;
              w_cnt_next   = CNT_DUMMY;
            end else begin
              w_state_next = S_RDATA;
              w_cnt_next   = CNT_WORD;
              w_load       = 1'b1;
              w_rd_idx     = w_sh_in_next[IW+1:2];
            end
          end else begin
            w_cnt_next = r_cnt - CW'(1);
          end
        end
        S_DUMMY: if (w_rise) begin
          if (r_cnt == '0) begin
            w_state_next = S_RDATA;
            w_cnt_next   = CNT_WORD;
            w_load       = 1'b1;
          end else begin
            w_cnt_next = r_cnt - CW'(1);
          end
        end
        S_WDATA: if (w_rise) begin
          if (r_cnt == '0) begin
            w_commit = 1'b1;
`ifdef SPI_TARGET_AUTOINC_EN
            w_cnt_next   = CNT_WORD;
`else
            w_state_next = S_CMD;
            w_cnt_next   = CNT_BYTE;
`endif
          end else begin
            w_cnt_next = r_cnt - CW'(1);
          end
        end
        S_RDATA: if (w_rise) begin
          if (r_cnt == '0) begin
            w_rd_done = 1'b1;
`ifdef SPI_TARGET_AUTOINC_EN
            w_load     = 1'b1;
            w_rd_idx   = w_addr_inc[IW+1:2];
            w_cnt_next = CNT_WORD;
`else
            w_state_next = S_CMD;
            w_cnt_next   = CNT_BYTE;
`endif
          end else begin
            w_shift    = 1'b1;
            w_cnt_next = r_cnt - CW'(1);
          end
        end
        S_IGNORE: ;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sclk_q   <= 1'b0;
      r_sh_in    <= '0;
      r_sh_out   <= '0;
      r_addr     <= '0;
      r_mode_rd  <= 1'b0;
      r_sdo      <= 1'b0;
      r_oe       <= 1'b0;
      r_wr_valid <= 1'b0;
      r_cmd_err  <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_txn      <= '0;
    end else begin
      r_sclk_q   <= spi_sclk_i;
      r_wr_valid <= w_commit;
      r_cmd_err  <= w_cmd_err;
      if (!spi_cs_i && w_rise &&
          (r_state == S_CMD || r_state == S_ADDR || r_state == S_WDATA))
        r_sh_in <= w_sh_in_next;
      if (w_cmd_done)  r_mode_rd <= (w_sh_in_next[7:0] == 8'h0B);
      if (w_addr_done) r_addr    <= w_sh_in_next;
      if (w_commit) begin
        r_wr_addr <= r_addr;
        r_wr_data <= w_sh_in_next;
        r_txn     <= r_txn + 8'd1;
`ifdef SPI_TARGET_AUTOINC_EN
        r_addr    <= w_addr_inc;
`endif
      end
      if (w_rd_done) begin
        r_txn  <= r_txn + 8'd1;
`ifdef SPI_TARGET_AUTOINC_EN
        r_addr <= w_addr_inc;
`endif
      end
      // A burst reload asserts load and done together; load wins so OE stays high.
      if (spi_cs_i) begin
        r_sdo <= 1'b0;
        r_oe  <= 1'b0;
      end else if (w_load) begin
        r_sdo    <= w_rd_word[31];
        r_sh_out <= {w_rd_word[30:0], 1'b0};
        r_oe     <= 1'b1;
      end else if (w_shift) begin
        r_sdo    <= r_sh_out[31];
        r_sh_out <= {r_sh_out[30:0], 1'b0};
      end else if (w_rd_done) begin
        r_sdo <= 1'b0;
        r_oe  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_commit) r_mem[r_addr[IW+1:2]] <= w_sh_in_next;
  end

  assign spi_sdo_o   = r_sdo;
  assign spi_oe_o    = r_oe;
  assign wr_valid_o  = r_wr_valid;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;
  assign cmd_err_o   = r_cmd_err;
  assign txn_count_o = r_txn;
endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: transaction-level memory/count model checked every clock cycle.
module tb_spi_target;
  localparam int MEM_DEPTH = 64;
  localparam int DUMMY     = 34;
`ifdef SPI_TARGET_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sclk = 1'b0;
  logic        sdi = 1'b0;
  logic        cs = 1'b1;
  logic        spi_sdo_o, spi_oe_o, wr_valid_o, cmd_err_o;
  logic [31:0] wr_addr_o, wr_data_o;
  logic [7:0]  txn_count_o;

  always #5 clk = ~clk;

  spi_target #(.MEM_DEPTH(MEM_DEPTH), .DUMMY_CYCLES(DUMMY)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .spi_sclk_i  (sclk),
    .spi_sdi_i   (sdi),
    .spi_cs_i    (cs),
    .spi_sdo_o   (spi_sdo_o),
    .spi_oe_o    (spi_oe_o),
    .wr_valid_o  (wr_valid_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .cmd_err_o   (cmd_err_o),
    .txn_count_o (txn_count_o)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  bit          check_en = 1'b0;
  logic        exp_sdo = 1'b0, exp_oe = 1'b0, exp_valid = 1'b0, exp_err = 1'b0;
  logic [7:0]  exp_txn = 8'd0;
  logic [31:0] exp_wr_addr = 32'd0, exp_wr_data = 32'd0;
  bit          exp_wr_known = 1'b0, exp_sdo_known = 1'b1;
  int          oe_cycles = 0, err_pulses = 0, valid_pulses = 0;
  logic [31:0] mem_model [int];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    chk("oe", 32'(spi_oe_o), 32'(exp_oe));
    if (exp_sdo_known) chk("sdo", 32'(spi_sdo_o), 32'(exp_sdo));
    chk("wr_valid", 32'(wr_valid_o), 32'(exp_valid));
    chk("cmd_err", 32'(cmd_err_o), 32'(exp_err));
    chk("txn_count", 32'(txn_count_o), 32'(exp_txn));
    if (exp_wr_known) begin
      chk("wr_addr", wr_addr_o, exp_wr_addr);
      chk("wr_data", wr_data_o, exp_wr_data);
    end
    if (spi_oe_o === 1'b1)   oe_cycles++;
    if (cmd_err_o === 1'b1)  err_pulses++;
    if (wr_valid_o === 1'b1) valid_pulses++;
  endtask

  // One clock: compare on the falling edge, then advance past the rising edge.
  task automatic step();
    @(negedge clk);
    if (check_en) compare_cycle();
    @(posedge clk);
    #1;
    exp_valid = 1'b0;
    exp_err   = 1'b0;
  endtask

  function automatic int word_idx(input logic [31:0] a);
    return int'((a >> 2) % 32'(MEM_DEPTH));
  endfunction

  function automatic bit model_known(input logic [31:0] a);
    return mem_model.exists(word_idx(a));
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    if (mem_model.exists(word_idx(a))) return mem_model[word_idx(a)];
    return 32'h0;
  endfunction

  task automatic sclk_bit(input logic b);
    sdi = b; sclk = 1'b0; step();
    sclk = 1'b1; step();
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sclk_bit(v[i]);
  endtask

  task automatic cs_low();
    cs = 1'b0; sclk = 1'b0; step();
  endtask

  task automatic cs_high();
    cs = 1'b1; sclk = 1'b0; step();
    exp_oe = 1'b0; exp_sdo = 1'b0; exp_sdo_known = 1'b1;
    step();
  endtask

  task automatic data_word(input logic [31:0] a, input logic [31:0] d);
    for (int i = 31; i >= 0; i--) sclk_bit(d[i]);
    exp_valid    = 1'b1;
    exp_wr_addr  = a;
    exp_wr_data  = d;
    exp_wr_known = 1'b1;
    exp_txn++;
    mem_model[word_idx(a)] = d;
  endtask

  task automatic frame_write(input logic [31:0] a, input logic [31:0] d);
    send_bits(32'h02, 8);
    send_bits(a, 32);
    data_word(a, d);
  endtask

  task automatic read_header(input logic [31:0] a);
    logic [31:0] w;
    send_bits(32'h0B, 8);
    send_bits(a, 32);
    for (int i = 0; i < DUMMY; i++) sclk_bit(1'($urandom_range(0, 1)));
    w = model_word(a);
    exp_oe = 1'b1;
    exp_sdo = w[31];
    exp_sdo_known = model_known(a);
  endtask

  task automatic read_tail(input logic [31:0] a, input bit cont, output logic [31:0] got);
    logic [31:0] w, nw;
    w = model_word(a);
    got = '0;
    got[31] = spi_sdo_o;
    for (int k = 30; k >= 0; k--) begin
      sclk_bit(1'($urandom_range(0, 1)));
      exp_sdo = w[k];
      got[k] = spi_sdo_o;
    end
    sclk_bit(1'($urandom_range(0, 1)));
    exp_txn++;
    if (cont) begin
      nw = model_word(a + 32'd4);
      exp_oe = 1'b1;
      exp_sdo = nw[31];
      exp_sdo_known = model_known(a + 32'd4);
    end else begin
      exp_oe = 1'b0;
      exp_sdo = 1'b0;
      exp_sdo_known = 1'b1;
    end
  endtask

  initial begin
    logic [31:0] got;
    int v0;
    rst = 1'b1;
    step(); step();
    check_en = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("reset_txn", 32'(txn_count_o), 32'd0);

    // Plain write
    cs_low(); frame_write(32'd100, 32'd100); cs_high();
    $display("write addr=100 data=100 txn=%0d", txn_count_o);
    chk("t1_wr_addr", wr_addr_o, 32'd100);
    chk("t1_wr_data", wr_data_o, 32'd100);
    chk("t1_txn", 32'(txn_count_o), 32'd1);
    chk("t1_valid_pulses", valid_pulses, 32'd1);

    // Read-back after dummy edges
    oe_cycles = 0;
    cs_low(); read_header(32'd100); read_tail(32'd100, AUTOINC, got); cs_high();
    $display("read addr=100 data=0x%08h txn=%0d", got, txn_count_o);
    chk("t2_rdata", got, 32'h0000_0064);
    chk("t2_txn", 32'(txn_count_o), 32'd2);
`ifndef SPI_TARGET_AUTOINC_EN
    chk("t2_oe_cycles", oe_cycles, 32'd64);
`endif

    // Unsupported command followed by 72 edges
    v0 = valid_pulses; err_pulses = 0;
    cs_low(); send_bits(32'h55, 8); exp_err = 1'b1;
    send_bits(32'hA5A5_A5A5, 32); send_bits(32'h0F0F_1234, 32); send_bits(32'h02, 8);
    cs_high();
    $display("bad cmd 0x55 err_pulses=%0d txn=%0d", err_pulses, txn_count_o);
    chk("t3_err_pulses", err_pulses, 32'd1);
    chk("t3_no_write", valid_pulses, v0);
    chk("t3_txn", 32'(txn_count_o), 32'd2);
    cs_low(); frame_write(32'd4, 32'hDEAD_BEEF); cs_high();
    $display("write addr=4 data=0x%08h txn=%0d", wr_data_o, txn_count_o);
    chk("t3_wr_addr", wr_addr_o, 32'd4);
    chk("t3_wr_data", wr_data_o, 32'hDEAD_BEEF);
    chk("t3_txn_after", 32'(txn_count_o), 32'd3);

    // Abort after 20 data bits
    v0 = valid_pulses;
    cs_low(); send_bits(32'h02, 8); send_bits(32'd100, 32); send_bits(32'hFFFFF, 20); cs_high();
    chk("t4_no_write", valid_pulses, v0);
    chk("t4_txn", 32'(txn_count_o), 32'd3);
    cs_low(); read_header(32'd100); read_tail(32'd100, AUTOINC, got); cs_high();
    $display("abort then read addr=100 data=0x%08h txn=%0d", got, txn_count_o);
    chk("t4_mem25_kept", got, 32'h0000_0064);
    chk("t4_txn_after", 32'(txn_count_o), 32'd4);

    // Reset in the address phase
    cs_low(); send_bits(32'h02, 8); send_bits(32'h8, 10);
    rst = 1'b1; sclk = 1'b0; step();
    exp_oe = 1'b0; exp_sdo = 1'b0; exp_sdo_known = 1'b1; exp_txn = 8'd0; exp_wr_known = 1'b0;
    rst = 1'b0; cs = 1'b1; step();
    chk("t5_txn_reset", 32'(txn_count_o), 32'd0);
    cs_low(); frame_write(32'd8, 32'h1234_5678); cs_high();
    $display("reset then write addr=8 data=0x%08h txn=%0d", wr_data_o, txn_count_o);
    chk("t5_wr_data", wr_data_o, 32'h1234_5678);
    chk("t5_txn", 32'(txn_count_o), 32'd1);

`ifndef SPI_TARGET_AUTOINC_EN
    // Write then read in one CS window
    cs_low(); frame_write(32'd200, 32'hA5A5_0F0F); read_header(32'd200); read_tail(32'd200, 1'b0, got); cs_high();
    $display("same-window read addr=200 data=0x%08h txn=%0d", got, txn_count_o);
    chk("t6_same_window", got, 32'hA5A5_0F0F);
    chk("t6_txn", 32'(txn_count_o), 32'd3);
`endif

    // Aliased, unaligned address reaches word 25
    cs_low(); read_header(32'd359); read_tail(32'd359, AUTOINC, got); cs_high();
    $display("alias read addr=359 data=0x%08h", got);
    chk("t7_alias", got, 32'h0000_0064);

`ifdef SPI_TARGET_AUTOINC_EN
    rst = 1'b1; step();
    exp_txn = 8'd0; exp_wr_known = 1'b0;
    rst = 1'b0; step();
    v0 = valid_pulses;
    cs_low(); send_bits(32'h02, 8); send_bits(32'd0, 32);
    data_word(32'd0, 32'd1); data_word(32'd4, 32'd2); data_word(32'd8, 32'd3);
    cs_high();
    $display("burst write 3 words txn=%0d last_addr=%0d", txn_count_o, wr_addr_o);
    chk("t8_valid_pulses", valid_pulses - v0, 32'd3);
    chk("t8_last_addr", wr_addr_o, 32'd8);
    chk("t8_txn", 32'(txn_count_o), 32'd3);
    begin
      logic [31:0] g1;
      cs_low(); read_header(32'd0); read_tail(32'd0, 1'b1, got); read_tail(32'd4, 1'b1, g1); cs_high();
      $display("burst read data0=0x%08h data1=0x%08h", got, g1);
      chk("t8_rd0", got, 32'd1);
      chk("t8_rd1", g1, 32'd2);
      chk("t8_rd_txn", 32'(txn_count_o), 32'd5);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI responder that terminates the bus driven by the stimuli master (`spi_master`).
- Deserialises command, 32-bit address and 32-bit data frames; stores write data in a local word memory; serialises read data back on its output.
- Sits on the FPGA stimuli board beside the master, sharing `clk_i`. Used as a loopback target for bring-up before the DUT SPI device is attached.

Parameters:
- `MEM_DEPTH`, 64: number of 32-bit words in local memory (power of 2).
- `DUMMY_CYCLES`, 34: sclk rising edges between the last address bit and the first read data bit. Matches `spi_master`.

Ports:
- `clk_i` input 1: system clock; also the master's clock.
- `rst_i` input 1: synchronous, active-high reset.
- `spi_sclk_i` input 1: SPI clock, synchronous to `clk_i`, toggles at most once per `clk_i`.
- `spi_sdi_i` input 1: serial data from master, MSB first.
- `spi_cs_i` input 1: chip select, active low.
- `spi_sdo_o` output 1: serial read data to master.
- `spi_oe_o` output 1: high while `spi_sdo_o` carries read data.
- `wr_valid_o` output 1: one-cycle pulse when a write word commits.
- `wr_addr_o` output 32: byte address of the committed write.
- `wr_data_o` output 32: data of the committed write.
- `cmd_err_o` output 1: one-cycle pulse on an unsupported command byte.
- `txn_count_o` output 8: count of completed transactions, wraps 255->0.

Behaviour:
- One clock, `clk_i`. Reset `rst_i` is synchronous and active-high.
- No synchronisers; all SPI inputs are in the `clk_i` domain.
- `sclk_q` registers `spi_sclk_i`. Rising edge = `spi_sclk_i & ~sclk_q`. All sampling happens on rising edges with `spi_cs_i` low.
- Reset values: state IDLE, counters 0, `spi_sdo_o` 0, `spi_oe_o` 0, `wr_valid_o` 0, `cmd_err_o` 0, `txn_count_o` 0, `sclk_q` 0. Memory contents are not reset.
- `spi_cs_i` high in any state:
  - Next cycle returns to IDLE; `spi_oe_o` = 0, `spi_sdo_o` = 0.
  - Partial frames are discarded: no write, no count increment.
  - Has priority over a simultaneous rising edge.
- Reset mid-transaction has the same effect as CS high plus the reset values above.
- States and transitions:
  - IDLE: `spi_cs_i` low -> CMD; bit counter = 7.
  - CMD: shift 8 bits MSB first. After the 8th edge:
    - cmd 0x02 -> ADDR, mode write.
    - cmd 0x0B -> ADDR, mode read.
    - other -> IGNORE; `cmd_err_o` pulses for 1 cycle.
  - ADDR: shift 32 bits. After the 32nd edge:
    - write -> WDATA.
    - read with `DUMMY_CYCLES` > 0 -> DUMMY.
    - read with `DUMMY_CYCLES` = 0 -> RDATA.
  - DUMMY: count `DUMMY_CYCLES` rising edges; `spi_sdi_i` ignored. After the last -> RDATA.
  - WDATA: shift 32 bits. After the 32nd edge, the next cycle:
    - mem[addr[log2(MEM_DEPTH)+1:2]] <= data.
    - `wr_valid_o` = 1 for 1 cycle; `wr_addr_o`/`wr_data_o` take the frame values and hold until the next commit.
    - `txn_count_o` +1.
    - -> CMD with bit counter 7 (back-to-back frames under one CS).
  - RDATA:
    - Entry edge (last address or dummy edge): load shift register from mem[word index]; next cycle `spi_sdo_o` = bit31, `spi_oe_o` = 1.
    - Each following rising edge shifts out the next bit, so bit k stays stable for one full sclk period.
    - On the 32nd edge: `spi_oe_o` -> 0, `spi_sdo_o` -> 0, `txn_count_o` +1, -> CMD with bit counter 7.
  - IGNORE: stays until `spi_cs_i` high.
- Address handling:
  - `addr[1:0]` ignored, word-aligned.
  - Bits above the index wrap modulo `MEM_DEPTH`; 100 and 100+4*`MEM_DEPTH` alias.
- Read of a word written in the same CS window returns the new value.

Optional Feature:
- Macro: `SPI_TARGET_AUTOINC_EN`.
- Defined: after each WDATA/RDATA word, if CS is still low, the state stays in WDATA/RDATA with addr += 4 (burst).
  - No new command or address phase.
  - Read bursts skip DUMMY.
  - Each word commits, pulses and counts individually.
  - Address wraps at 2^32.
- Undefined: each word returns to CMD as described in Behaviour.

Test Plan:
- Write: CS low, cmd 0x02, addr 100, data 100 -> `wr_valid_o` pulse, `wr_addr_o` = 100, `wr_data_o` = 100, `txn_count_o` = 1.
- Read-back after the write: cmd 0x0B, addr 100, 34 dummy edges -> `spi_sdo_o` shifts 0x00000064 MSB first, `spi_oe_o` high for exactly 32 sclk periods, `txn_count_o` = 2.
- Unsupported cmd 0x55 then 72 more edges -> `cmd_err_o` single pulse, no `wr_valid_o`, count unchanged; next CS frame (cmd 0x02, addr 4, data 0xDEADBEEF) commits normally.
- Abort: CS high after 20 WDATA bits -> no write, mem[25] keeps its old value, state IDLE within 1 cycle.
- Reset: `rst_i` high during ADDR -> all outputs at reset values next cycle; a subsequent full write of addr 8, data 0x12345678 succeeds.
- With `SPI_TARGET_AUTOINC_EN`: cmd 0x02, addr 0, data words 1, 2, 3 under one CS -> three `wr_valid_o` pulses at addresses 0, 4, 8; `txn_count_o` = 3.
